// File: rtl/aes256_inv_key_expansion_seq_pkg.sv
// Types, widths and GF(2^8) helpers for the reverse AES-256 key schedule.
`include "aes_defines.svh"

package aes256_inv_key_expansion_seq_pkg;

  localparam int WORD_W  = `AES_WORD_SIZE;
  localparam int BLOCK_W = `AES_BLOCK_SIZE;
  localparam int KEY_W   = `AES_256_KEY_LENGTH;
  localparam int ROUND_W = 4;
  localparam logic [ROUND_W-1:0] FIRST_ROUND = ROUND_W'(`AES_256_ROUNDS);

  // hi = round key r-1, lo = round key r (the one on the output)
  typedef struct packed {
    logic [BLOCK_W-1:0] hi;
    logic [BLOCK_W-1:0] lo;
  } window_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (maps 0 to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_rcon(input logic [2:0] n);
    logic [7:0] rc;
    rc = 8'h00;
    case (n)
      3'd1:    rc = `AES_RCON_01;
      3'd2:    rc = `AES_RCON_02;
      3'd3:    rc = `AES_RCON_03;
      3'd4:    rc = `AES_RCON_04;
      3'd5:    rc = `AES_RCON_05;
      3'd6:    rc = `AES_RCON_06;
      3'd7:    rc = `AES_RCON_07;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes256_inv_key_step.sv
// One reverse AES-256 schedule step: from the window {key r-1, key r} produce key r-2.
// Purely combinational; f() uses the last word of key r-1, the xor chain uses key r words.
`include "aes_defines.svh"

module aes256_inv_key_step
  import aes256_inv_key_expansion_seq_pkg::*;
(
  input  logic [KEY_W-1:0]   i_window,
  input  logic [ROUND_W-1:0] i_round,
  output logic [BLOCK_W-1:0] o_prev_key
);

  window_t             w_win;
  logic [WORD_W-1:0]   w_hi_last;
  logic [WORD_W-1:0]   w_sub_in;
  logic [WORD_W-1:0]   w_sub_out;
  logic [WORD_W-1:0]   w_g;
  logic [WORD_W-1:0]   w_lo [4];

  assign w_win     = i_window;
  assign w_hi_last = `AES_WORD(w_win.hi, 3);

  // Even rounds sit on an 8-word boundary of the forward schedule: RotWord + Rcon.
  assign w_sub_in = i_round[0] ? w_hi_last : {w_hi_last[23:0], w_hi_last[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_sub_in[8*b +: 8]),
      .o_byte (w_sub_out[8*b +: 8])
    );
  end

  assign w_g = w_sub_out ^ (i_round[0] ? '0 : {aes_rcon(i_round[3:1]), 24'h000000});

  for (genvar m = 0; m < 4; m++) begin : g_lo
    assign w_lo[m] = `AES_WORD(w_win.lo, m);
  end

  assign o_prev_key = {w_lo[0] ^ w_g,
                       w_lo[1] ^ w_lo[0],
                       w_lo[2] ^ w_lo[1],
                       w_lo[3] ^ w_lo[2]};

endmodule

// File: rtl/aes_defines.svh
// Shared AES constants and word-select helpers for the key schedule and cipher datapaths.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES_WORD_SIZE      32
`define AES_BLOCK_SIZE     128
`define AES_256_KEY_LENGTH 256
`define AES_256_ROUNDS     14

`define AES_RCON_01 8'h01
`define AES_RCON_02 8'h02
`define AES_RCON_03 8'h04
`define AES_RCON_04 8'h08
`define AES_RCON_05 8'h10
`define AES_RCON_06 8'h20
`define AES_RCON_07 8'h40

// Word n of a 128-bit block, word 0 in the MSBs.
`define AES_WORD(blk, n) blk[`AES_BLOCK_SIZE-1-(n)*`AES_WORD_SIZE -: `AES_WORD_SIZE]

`endif

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
  import aes256_inv_key_expansion_seq_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = sbox_byte(i_byte);

endmodule

// File: rtl/aes256_inv_key_expansion_seq.sv
// Streams AES-256 round keys 14 down to LAST_ROUND from the final key window, one per cycle.
// First key one cycle after the accept; output registers hold while the consumer stalls.
module aes256_inv_key_expansion_seq
  import aes256_inv_key_expansion_seq_pkg::*;
#(
  parameter int LAST_ROUND = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_key_valid,
  output logic               o_key_ready,
  input  logic [KEY_W-1:0]   i_final_key,
  output logic               o_round_key_valid,
  input  logic               i_round_key_ready,
  output logic [BLOCK_W-1:0] o_round_key,
  output logic [ROUND_W-1:0] o_round_idx,
  output logic               o_round_key_last
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(LAST_ROUND);

  state_t               r_state;
  state_t               w_state_nxt;
  window_t              r_window;
  window_t              w_window_nxt;
  logic [ROUND_W-1:0]   r_round;
  logic [ROUND_W-1:0]   w_round_nxt;
  logic [BLOCK_W-1:0]   w_prev_key;

  aes256_inv_key_step u_step (
    .i_window   (r_window),
    .i_round    (r_round),
    .o_prev_key (w_prev_key)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_window_nxt = r_window;
    w_round_nxt  = r_round;
    unique case (r_state)
      IDLE: begin
        if (i_key_valid) begin
          w_window_nxt = i_final_key;
          w_round_nxt  = FIRST_ROUND;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
        if (i_round_key_ready) begin
          if (r_round == LAST_IDX) begin
            w_state_nxt = IDLE;
          end else begin
            w_window_nxt.lo = r_window.hi;
            w_round_nxt     = r_round - 1'b1;
            // Below round 2 there is no earlier key left to derive.
            if (r_round >= 4'd2) w_window_nxt.hi = w_prev_key;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_window <= '0;
      r_round  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_window <= w_window_nxt;
      r_round  <= w_round_nxt;
    end
  end

  assign o_key_ready       = (r_state == IDLE);
  assign o_round_key_valid = (r_state == RUN);
  assign o_round_key       = r_window.lo;
  assign o_round_idx       = r_round;
  assign o_round_key_last  = (r_state == RUN) && (r_round == LAST_IDX);

endmodule

// File: tb/tb_aes256_inv_key_expansion_seq.sv
// Bench for the reverse AES-256 key schedule: golden forward expansion feeds a scoreboard.
module tb_aes256_inv_key_expansion_seq;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } exp_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         kvld  [3];
  logic         krdy  [3];
  logic [255:0] fkey  [3];
  logic         rvld  [3];
  logic         rrdy  [3];
  logic [127:0] rkey  [3];
  logic [3:0]   ridx  [3];
  logic         rlast [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb_tab [256];
  logic [31:0]  gw [60];
  logic [127:0] cap_key [15];
  logic         cap_last [15];
  exp_t         sbq [$];
  vec_t         fips_tab [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes256_inv_key_expansion_seq #(
      .LAST_ROUND (g == 0 ? 0 : (g == 1 ? 5 : 13))
    ) u_dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_key_valid       (kvld[g]),
      .o_key_ready       (krdy[g]),
      .i_final_key       (fkey[g]),
      .o_round_key_valid (rvld[g]),
      .i_round_key_ready (rrdy[g]),
      .o_round_key       (rkey[g]),
      .o_round_idx       (ridx[g]),
      .o_round_key_last  (rlast[g])
    );
  end

  function automatic int lr_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 5 : 13);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // S-box by walking the generator 3 and its inverse through the field.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb_tab[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_tab[x[31:24]], sb_tab[x[23:16]], sb_tab[x[15:8]], sb_tab[x[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) gw[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = gw[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01 << (i / 8 - 1);
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      gw[i] = gw[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] gold_rk(input int r);
    return {gw[4*r], gw[4*r+1], gw[4*r+2], gw[4*r+3]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Drive one key into instance d and drain its stream through the scoreboard.
  task automatic run_stream(input int d, input logic [255:0] k, input int pct,
                            input bit pulse, input int abort_idx);
    int           lr, nkeys, fired, cyc;
    bit           aborting;
    logic         hold;
    logic [127:0] hkey;
    logic [3:0]   hidx;
    logic [255:0] fk;
    exp_t         e;
    lr    = lr_of(d);
    nkeys = 15 - lr;
    expand(k);
    fk = {gold_rk(13), gold_rk(14)};
    for (int r = 14; r >= lr; r--) begin
      e.idx  = 4'(r);
      e.key  = gold_rk(r);
      e.last = (r == lr);
      sbq.push_back(e);
    end
    for (int i = 0; i < 15; i++) begin
      cap_key[i]  = '0;
      cap_last[i] = 1'b0;
    end
    for (int i = 0; i < 20 && krdy[d] !== 1'b1; i++) @(negedge clk);
    chk("key_ready_idle", 128'(krdy[d]), 128'd1);
    kvld[d] = 1'b1;
    fkey[d] = fk;
    @(negedge clk);
    kvld[d] = 1'b0;
    fkey[d] = rand256();
    fired = 0; cyc = 0; hold = 1'b0; hkey = '0; hidx = '0; aborting = 1'b0;
    while (sbq.size() > 0 && cyc < 400 && !aborting) begin
      chk("key_ready_run", 128'(krdy[d]), 128'd0);
      chk("round_key_valid", 128'(rvld[d]), 128'd1);
      if (hold) begin
        chk("stall_key", rkey[d], hkey);
        chk("stall_idx", 128'(ridx[d]), 128'(hidx));
      end
      rrdy[d] = ($urandom_range(99) < pct);
      if (pulse) begin
        kvld[d] = 1'($urandom_range(1));
        fkey[d] = rand256();
      end
      if (rvld[d] === 1'b1 && rrdy[d]) begin
        e = sbq.pop_front();
        chk("round_idx", 128'(ridx[d]), 128'(e.idx));
        chk("round_key", rkey[d], e.key);
        chk("round_last", 128'(rlast[d]), 128'(e.last));
        if (ridx[d] <= 4'd14) begin
          cap_key[ridx[d]]  = rkey[d];
          cap_last[ridx[d]] = rlast[d];
        end
        fired++;
        hold = 1'b0;
        if (int'(e.idx) == abort_idx) aborting = 1'b1;
      end else begin
        hold = (rvld[d] === 1'b1);
        hkey = rkey[d];
        hidx = ridx[d];
      end
      @(negedge clk);
      cyc++;
    end
    rrdy[d] = 1'b0;
    kvld[d] = 1'b0;
    if (aborting) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", 128'(rvld[d]), 128'd0);
      chk("abort_key_ready", 128'(krdy[d]), 128'd1);
      chk("abort_round_key", rkey[d], 128'd0);
      chk("abort_round_idx", 128'(ridx[d]), 128'd0);
      chk("abort_last", 128'(rlast[d]), 128'd0);
      sbq.delete();
    end else begin
      chk("stream_pending", 128'(sbq.size()), 128'd0);
      sbq.delete();
      chk("n_outputs", 128'(fired), 128'(nkeys));
      chk("end_key_ready", 128'(krdy[d]), 128'd1);
      chk("end_valid", 128'(rvld[d]), 128'd0);
      if (pct == 100) chk("consecutive", 128'(cyc), 128'(nkeys));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] fips_key;
    logic [255:0] k;

    build_sbox();
    fips_tab[0] = '{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0};
    fips_tab[1] = '{4'd2,  128'ha573c29fa176c498a97fce93a572c09c, 1'b0};
    fips_tab[2] = '{4'd1,  128'h101112131415161718191a1b1c1d1e1f, 1'b0};
    fips_tab[3] = '{4'd0,  128'h000102030405060708090a0b0c0d0e0f, 1'b1};
    fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      kvld[d] = 1'b0;
      rrdy[d] = 1'b0;
      fkey[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_key_ready", 128'(krdy[d]), 128'd1);
      chk("rst_valid", 128'(rvld[d]), 128'd0);
      chk("rst_round_key", rkey[d], 128'd0);
      chk("rst_round_idx", 128'(ridx[d]), 128'd0);
      chk("rst_last", 128'(rlast[d]), 128'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_stream(0, fips_key, 100, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      chk("fips_key", cap_key[fips_tab[i].idx], fips_tab[i].key);
      chk("fips_last", 128'(cap_last[fips_tab[i].idx]), 128'(fips_tab[i].last));
    end

    run_stream(0, fips_key, 50, 1'b0, -1);

    run_stream(0, rand256(), 100, 1'b1, -1);
    run_stream(0, fips_key, 60, 1'b0, -1);

    run_stream(0, rand256(), 100, 1'b0, 9);
    run_stream(0, fips_key, 100, 1'b0, -1);

    run_stream(1, fips_key, 100, 1'b0, -1);
    chk("lr5_last", 128'(cap_last[5]), 128'd1);
    run_stream(2, fips_key, 100, 1'b0, -1);
    chk("lr13_last", 128'(cap_last[13]), 128'd1);
    for (int i = 0; i < 5; i++) begin
      run_stream(1, rand256(), 70, 1'b0, -1);
      run_stream(2, rand256(), 70, 1'b0, -1);
    end

    for (int i = 0; i < 1000; i++) begin
      k = rand256();
      run_stream(0, k, (i % 4 == 0) ? 50 : 100, 1'b0, -1);
      chk("rk0_orig", cap_key[0], k[255:128]);
      chk("rk1_orig", cap_key[1], k[127:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
